mem_sort_ctrl: RTL and testbench

In-place bubble-sort initiator that drives the single-port word memory's `addr/wdata/we/re/en` interface as bus master. On `start` it reads adjacent word pairs, compares them, writes them back swapped when out of order, and repeats passes until the array is sorted. It sits between the top-level sorter sequencer and the memory instance, and owns the memory port exclusively while `busy` is high.

---
 rtl/mem_sort_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_mem_sort_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sort_ctrl.sv
// mem_sort_ctrl
//   In-place bubble-sort initiator. Owns a single-port word memory while
//   busy_o is high: reads adjacent word pairs, compares them (unsigned),
//   writes them back swapped when out of order, and repeats passes until a
//   pass makes no swap or the last pass is reached.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      sort request, sampled only in IDLE
//   desc_i       order select sampled with start_i (0 ascending, 1 descending)
//   busy_o       high from the cycle after an accepted start through DONE
//   done_o       one-cycle pulse in DONE
//   swap_cnt_o   swaps in the current/last sort, saturating
//   mem_addr_o   memory address
//   mem_wdata_o  memory write data
//   mem_we_o     memory write strobe
//   mem_re_o     memory read strobe
//   mem_en_o     memory enable, active-low
//   mem_rdata_i  memory read data, combinational in the read cycle
module mem_sort_ctrl #(
    parameter int SIZE   = 8,
    parameter int ADDR_W = $clog2(SIZE) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              desc_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [15:0]       swap_cnt_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    output logic              mem_en_o,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_CMP,
        S_WR_A,
        S_WR_B,
        S_PASS_END,
        S_DONE
    } state_t;

    // A single word is already sorted: go straight to DONE.
    localparam bit                SINGLE = (SIZE == 1);
    // Index of the final pass (SIZE-2); unused when SIZE is 1.
    localparam logic [ADDR_W-1:0] LAST_P = (SIZE >= 2) ? ADDR_W'(SIZE - 2) : '0;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] p_q, p_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic              swapped_q, swapped_d;
    logic              desc_q, desc_d;
    logic [15:0]       swap_cnt_q, swap_cnt_d;

    logic [ADDR_W-1:0] i_next;
    logic              last_pair;
    logic              swap_req;

    assign i_next    = i_q + ADDR_W'(1);
    // Pass p compares pairs 0..SIZE-2-p; the tail is already in place.
    assign last_pair = (i_q == (LAST_P - p_q));
    assign swap_req  = desc_q ? (a_q < b_q) : (a_q > b_q);

    assign swap_cnt_o = swap_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            p_q        <= '0;
            i_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            swapped_q  <= 1'b0;
            desc_q     <= 1'b0;
            swap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            i_q        <= i_d;
            a_q        <= a_d;
            b_q        <= b_d;
            swapped_q  <= swapped_d;
            desc_q     <= desc_d;
            swap_cnt_q <= swap_cnt_d;
        end
    end

    // Outputs are decoded from state and registers only; mem_rdata_i only
    // feeds the operand registers.
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        i_d         = i_q;
        a_d         = a_q;
        b_d         = b_q;
        swapped_d   = swapped_q;
        desc_d      = desc_q;
        swap_cnt_d  = swap_cnt_q;

        busy_o      = (state_q != S_IDLE);
        done_o      = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_we_o    = 1'b0;
        mem_re_o    = 1'b0;
        mem_en_o    = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    swap_cnt_d = '0;
                    p_d        = '0;
                    i_d        = '0;
                    swapped_d  = 1'b0;
                    desc_d     = desc_i;
                    state_d    = SINGLE ? S_DONE : S_RD_A;
                end
            end

            S_RD_A: begin
                mem_addr_o = i_q;
                mem_re_o   = 1'b1;
                mem_en_o   = 1'b0;
                a_d        = mem_rdata_i;
                state_d    = S_RD_B;
            end

            S_RD_B: begin
                mem_addr_o = i_next;
                mem_re_o   = 1'b1;
                mem_en_o   = 1'b0;
                b_d        = mem_rdata_i;
                state_d    = S_CMP;
            end

            S_CMP: begin
                if (swap_req) begin
                    state_d = S_WR_A;
                end else if (last_pair) begin
                    state_d = S_PASS_END;
                end else begin
                    i_d     = i_next;
                    state_d = S_RD_A;
                end
            end

            S_WR_A: begin
                mem_addr_o  = i_q;
                mem_wdata_o = b_q;
                mem_we_o    = 1'b1;
                mem_en_o    = 1'b0;
                state_d     = S_WR_B;
            end

            S_WR_B: begin
                mem_addr_o  = i_next;
                mem_wdata_o = a_q;
                mem_we_o    = 1'b1;
                mem_en_o    = 1'b0;
                swapped_d   = 1'b1;
                if (swap_cnt_q != 16'hFFFF) begin
                    swap_cnt_d = swap_cnt_q + 16'd1;
                end
                if (last_pair) begin
                    state_d = S_PASS_END;
                end else begin
                    i_d     = i_next;
                    state_d = S_RD_A;
                end
            end

            S_PASS_END: begin
                if (!swapped_q || (p_q == LAST_P)) begin
                    state_d = S_DONE;
                end else begin
                    p_d       = p_q + ADDR_W'(1);
                    i_d       = '0;
                    swapped_d = 1'b0;
                    state_d   = S_RD_A;
                end
            end

            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_sort_ctrl.sv
// tb_mem_sort_ctrl
//   Table-driven bench for mem_sort_ctrl (SIZE=8) with a behavioural
//   single-port memory, plus hand-written sequences for mid-sort reset,
//   ignored starts, start held through DONE, and a SIZE=1 instance.
module tb_mem_sort_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, desc;
    logic        busy, done;
    logic [15:0] swap_cnt;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_we, mem_re, mem_en;

    logic        s1_start;
    logic        s1_busy, s1_done;
    logic [15:0] s1_swap_cnt;
    logic [0:0]  s1_addr;
    logic [31:0] s1_wdata;
    logic        s1_we, s1_re, s1_en;

    logic [7:0][31:0] mem;
    logic [7:0][31:0] ld_img;
    logic             ld;

    int checks   = 0;
    int failures = 0;

    mem_sort_ctrl #(.SIZE(8), .ADDR_W(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .desc_i      (desc),
        .busy_o      (busy),
        .done_o      (done),
        .swap_cnt_o  (swap_cnt),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_we_o    (mem_we),
        .mem_re_o    (mem_re),
        .mem_en_o    (mem_en),
        .mem_rdata_i (mem_rdata)
    );

    mem_sort_ctrl #(.SIZE(1), .ADDR_W(1)) dut1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (s1_start),
        .desc_i      (1'b0),
        .busy_o      (s1_busy),
        .done_o      (s1_done),
        .swap_cnt_o  (s1_swap_cnt),
        .mem_addr_o  (s1_addr),
        .mem_wdata_o (s1_wdata),
        .mem_we_o    (s1_we),
        .mem_re_o    (s1_re),
        .mem_en_o    (s1_en),
        .mem_rdata_i (32'h0)
    );

    assign mem_rdata = mem[mem_addr[2:0]];

    always @(posedge clk) begin
        if (ld) mem <= ld_img;
        else if (!mem_en && mem_we) mem[mem_addr[2:0]] <= mem_wdata;
    end

    typedef struct {
        logic [7:0][31:0] init;
        logic             d;
        logic [7:0][31:0] exp;
        int               swaps;
        int               cycles;
        int               writes;
    } vec_t;

    vec_t vt[5];

    function automatic logic [7:0][31:0] mk(input logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7);
        logic [7:0][31:0] r;
        r[0] = w0; r[1] = w1; r[2] = w2; r[3] = w3;
        r[4] = w4; r[5] = w5; r[6] = w6; r[7] = w7;
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [7:0][31:0] img);
        @(negedge clk);
        ld_img = img;
        ld     = 1'b1;
        @(negedge clk);
        ld     = 1'b0;
    endtask

    // Starts a sort, then follows it cycle by cycle until done (cyc = -1 on
    // timeout). desc is flipped right after acceptance to show it is latched.
    task automatic run_sort(input logic d, input int limit, output int cyc,
                            output int writes, output int berr);
        bit seen;
        seen = 1'b0; cyc = 0; writes = 0; berr = 0;
        @(negedge clk);
        start = 1'b1;
        desc  = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        desc  = ~d;
        while (!seen && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (mem_we) writes++;
            if ((mem_we && mem_re) || !busy || (mem_en && (mem_we || mem_re))) berr++;
            if (done) seen = 1'b1;
        end
        if (!seen) cyc = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc, wr, berr;
        bit  seen;
        logic [7:0][31:0] asc, rev;

        asc = mk(1, 2, 3, 4, 5, 6, 7, 8);
        rev = mk(8, 7, 6, 5, 4, 3, 2, 1);

        vt[0] = '{init: asc, d: 1'b0, exp: asc, swaps: 0, cycles: 23, writes: 0};
        vt[1] = '{init: rev, d: 1'b0, exp: asc, swaps: 28, cycles: 148, writes: 56};
        vt[2] = '{init: mk(5, 3, 5, 1, 3, 1, 5, 0), d: 1'b0,
                  exp: mk(0, 1, 1, 3, 3, 5, 5, 5), swaps: 17, cycles: 126, writes: 34};
        vt[3] = '{init: asc, d: 1'b1, exp: rev, swaps: 28, cycles: 148, writes: 56};
        vt[4] = '{init: mk(1, 32'hFFFF_FFFF, 2, 3, 4, 5, 6, 7), d: 1'b0,
                  exp: mk(1, 2, 3, 4, 5, 6, 7, 32'hFFFF_FFFF), swaps: 6, cycles: 54, writes: 12};

        rst_n = 1'b0; start = 1'b0; desc = 1'b0; s1_start = 1'b0; ld = 1'b0;
        ld_img = '0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_swap_cnt", swap_cnt, 0);
        chk("rst_en", mem_en, 1);
        chk("rst_we_re", {mem_we, mem_re}, 0);
        chk("rst_addr_wdata", {mem_addr, mem_wdata}, 0);
        chk("rst_s1_en_busy", {s1_en, s1_busy}, 2'b10);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) begin
            load(vt[k].init);
            run_sort(vt[k].d, 400, cyc, wr, berr);
            chk($sformatf("v%0d_done_cycle", k), cyc, vt[k].cycles);
            chk($sformatf("v%0d_swap_cnt", k), swap_cnt, vt[k].swaps);
            chk($sformatf("v%0d_writes", k), wr, vt[k].writes);
            chk($sformatf("v%0d_bus_rules", k), berr, 0);
            chk($sformatf("v%0d_mem", k), mem, vt[k].exp);
            @(negedge clk);
            chk($sformatf("v%0d_after_done", k), {done, busy}, 2'b00);
        end

        // Reset during WR_A of pass 2 on a reversed array.
        load(rev);
        @(negedge clk);
        start = 1'b1; desc = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 71; c++) begin
            @(negedge clk);
            if (c == 1) chk("rs_first_read", {busy, mem_re, mem_en, mem_addr}, {3'b110, 4'd0});
        end
        chk("rs_in_wr_a", {mem_we, mem_en, mem_addr, mem_wdata}, {2'b10, 4'd0, 32'd5});
        rst_n = 1'b0;
        #1;
        chk("rs_en_idle", mem_en, 1);
        chk("rs_busy_we", {busy, mem_we, mem_re}, 0);
        chk("rs_swap_cnt", swap_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rs_mem_no_partial", mem, mk(6, 5, 4, 3, 2, 1, 7, 8));
        run_sort(1'b0, 400, cyc, wr, berr);
        chk("rs_resort_done", cyc > 0, 1);
        chk("rs_resort_mem", mem, asc);
        chk("rs_resort_swaps", swap_cnt, 15);

        // Start while busy is ignored; start held through DONE waits for IDLE.
        load(rev);
        @(negedge clk);
        start = 1'b1; desc = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
            else if (cyc == 5) begin start = 1'b1; desc = 1'b1; end
            else if (cyc == 6) start = 1'b0;
            else if (cyc == 140) begin start = 1'b1; desc = 1'b0; end
        end
        chk("ig_done_cycle", seen ? cyc : -1, 148);
        chk("ig_mem", mem, asc);
        chk("ig_swaps", swap_cnt, 28);
        @(negedge clk);
        chk("ig_idle_gap", busy, 0);
        @(negedge clk);
        chk("ig_restart", {busy, mem_re, mem_en, mem_addr}, {3'b110, 4'd0});
        start = 1'b0;
        cyc = 1; seen = done;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
        end
        chk("ig_second_done", seen ? cyc : -1, 23);
        chk("ig_second_swaps", swap_cnt, 0);

        // SIZE=1 instance: done in cycle 1, no memory access.
        @(negedge clk);
        s1_start = 1'b1;
        @(posedge clk);
        #1 s1_start = 1'b0;
        @(negedge clk);
        chk("s1_cycle1", {s1_done, s1_busy, s1_en, s1_we, s1_re}, 5'b11100);
        @(negedge clk);
        chk("s1_cycle2", {s1_done, s1_busy, s1_en}, 3'b001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
